// File: rtl/writeback_queue.sv
// -----------------------------------------------------------------------------
// writeback_queue
//
// Collects results from the load path (mem_*) and the ALU path (alu_*) and
// writes them into the register file one per cycle, in acceptance order.
// Pending entries can be looked up by source register index for forwarding.
//
// Handshake: a result on either path is accepted in a cycle where
// <path>_valid and <path>_ready are both high at the rising edge of clk.
// Ready depends only on registered occupancy (and on mem_valid for the ALU
// path), never on the same-cycle dequeue. An accepted result whose
// destination is x0 completes its handshake but is not stored.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   mem_valid/mem_rd/mem_data   load-path result         mem_ready  accept
//   alu_valid/alu_rd/alu_data   ALU-path result          alu_ready  accept
//   rf_reg_write/rf_rd/rf_write_data   register-file write port (head entry)
//   query_rs1/query_rs2         forwarding lookup indices
//   fwd_hit1/2, fwd_data1/2     youngest pending match per query
//   count                       number of occupied entries
// -----------------------------------------------------------------------------
module writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,

  input  logic                     mem_valid,
  input  logic [4:0]               mem_rd,
  input  logic [63:0]              mem_data,
  output logic                     mem_ready,

  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [63:0]              alu_data,
  output logic                     alu_ready,

  output logic                     rf_reg_write,
  output logic [4:0]               rf_rd,
  output logic [63:0]              rf_write_data,

  input  logic [4:0]               query_rs1,
  input  logic [4:0]               query_rs2,
  output logic                     fwd_hit1,
  output logic                     fwd_hit2,
  output logic [63:0]              fwd_data1,
  output logic [63:0]              fwd_data2,

  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Entry storage; contents need no reset because occupancy gates every read.
  logic [4:0]  rd_mem   [DEPTH];
  logic [63:0] data_mem [DEPTH];

  logic [CW-1:0] free;
  logic          mem_enq, alu_enq, deq;
  logic [PW-1:0] alu_ptr;

  // Credit comes from registered occupancy only.
  assign free = DEPTH_C - count_q;

  // When both paths present, the ALU needs a second slot behind the load.
  assign mem_ready = !reset && (free >= CW'(1));
  assign alu_ready = !reset && (mem_valid ? (free >= CW'(2)) : (free >= CW'(1)));

  assign mem_enq = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign alu_enq = alu_valid && alu_ready && (alu_rd != 5'd0);

  // The register file always accepts, so the head drains whenever present.
  assign deq = (count_q != '0);

  // Load entry is older: it takes the tail slot, ALU takes the next one.
  assign alu_ptr = tail_q + PW'(mem_enq);

  assign tail_d  = tail_q + PW'(mem_enq) + PW'(alu_enq);
  assign head_d  = head_q + PW'(deq);
  assign count_d = count_q + CW'(mem_enq) + CW'(alu_enq) - CW'(deq);

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_enq) begin
      rd_mem[tail_q]   <= mem_rd;
      data_mem[tail_q] <= mem_data;
    end
    if (alu_enq) begin
      rd_mem[alu_ptr]   <= alu_rd;
      data_mem[alu_ptr] <= alu_data;
    end
  end

  // Register-file port shows the head entry; all zero when empty or in reset.
  logic has_head;
  assign has_head      = !reset && (count_q != '0);
  assign rf_reg_write  = has_head;
  assign rf_rd         = has_head ? rd_mem[head_q]   : 5'd0;
  assign rf_write_data = has_head ? data_mem[head_q] : 64'd0;
  assign count         = reset ? '0 : count_q;

  // Forwarding lookup walks oldest to youngest so the last match wins.
  // Only registered occupancy is searched, which includes the head being
  // written this cycle and excludes anything being enqueued this cycle.
  logic [PW-1:0] fwd_idx;

  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = 64'd0;
    fwd_data2 = 64'd0;
    fwd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((query_rs1 != 5'd0) && (rd_mem[fwd_idx] == query_rs1)) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = data_mem[fwd_idx];
        end
        if ((query_rs2 != 5'd0) && (rd_mem[fwd_idx] == query_rs2)) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = data_mem[fwd_idx];
        end
      end
    end
    if (reset) begin
      fwd_hit1  = 1'b0;
      fwd_hit2  = 1'b0;
      fwd_data1 = 64'd0;
      fwd_data2 = 64'd0;
    end
  end

endmodule

// File: tb/tb_writeback_queue.sv
// -----------------------------------------------------------------------------
// tb_writeback_queue
//
// Directed stimulus with hand-computed literal expectations, plus a queue
// model (exp_q) of pending writes compared against the DUT on every negedge.
// Inputs are driven 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_writeback_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_rd, alu_rd;
  logic [63:0] mem_data, alu_data;
  logic        mem_ready, alu_ready;
  logic        rf_reg_write;
  logic [4:0]  rf_rd;
  logic [63:0] rf_write_data;
  logic [4:0]  query_rs1, query_rs2;
  logic        fwd_hit1, fwd_hit2;
  logic [63:0] fwd_data1, fwd_data2;
  logic [$clog2(DEPTH):0] count;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .query_rs1(query_rs1), .query_rs2(query_rs2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
    .count(count)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int n_acc  = 0;   // entries the model accepted (non-x0)
  int n_drop = 0;   // entries discarded by reset
  int n_wr   = 0;   // register-file writes seen from the DUT

  logic [68:0] exp_q[$];   // {rd, data}, oldest first

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  always @(negedge clk) begin
    int n, fr;
    logic e_mr, e_ar, h1, h2;
    logic [63:0] d1, d2;
    logic [4:0]  e_rd;
    logic [63:0] e_data;
    if (reset) begin
      check("rst_count", 64'(count), 64'd0);
      check("rst_mem_ready", 64'(mem_ready), 64'd0);
      check("rst_alu_ready", 64'(alu_ready), 64'd0);
      check("rst_rf_reg_write", 64'(rf_reg_write), 64'd0);
      check("rst_rf_rd", 64'(rf_rd), 64'd0);
      check("rst_rf_write_data", rf_write_data, 64'd0);
      check("rst_fwd_hit1", 64'(fwd_hit1), 64'd0);
      check("rst_fwd_hit2", 64'(fwd_hit2), 64'd0);
      check("rst_fwd_data1", fwd_data1, 64'd0);
      check("rst_fwd_data2", fwd_data2, 64'd0);
      n_drop += exp_q.size();
      exp_q.delete();
    end else begin
      n  = exp_q.size();
      fr = DEPTH - n;
      e_mr = (fr >= 1);
      e_ar = mem_valid ? (fr >= 2) : (fr >= 1);
      h1 = 1'b0; d1 = 64'd0;
      h2 = 1'b0; d2 = 64'd0;
      for (int i = n - 1; i >= 0; i--) begin
        if (!h1 && query_rs1 != 5'd0 && exp_q[i][68:64] == query_rs1) begin
          h1 = 1'b1; d1 = exp_q[i][63:0];
        end
        if (!h2 && query_rs2 != 5'd0 && exp_q[i][68:64] == query_rs2) begin
          h2 = 1'b1; d2 = exp_q[i][63:0];
        end
      end
      e_rd = 5'd0; e_data = 64'd0;
      if (n != 0) begin
        e_rd   = exp_q[0][68:64];
        e_data = exp_q[0][63:0];
      end
      check("m_count", 64'(count), 64'(n));
      check("m_mem_ready", 64'(mem_ready), 64'(e_mr));
      check("m_alu_ready", 64'(alu_ready), 64'(e_ar));
      check("m_rf_reg_write", 64'(rf_reg_write), 64'(n != 0));
      check("m_rf_rd", 64'(rf_rd), 64'(e_rd));
      check("m_rf_write_data", rf_write_data, e_data);
      check("m_fwd_hit1", 64'(fwd_hit1), 64'(h1));
      check("m_fwd_data1", fwd_data1, d1);
      check("m_fwd_hit2", 64'(fwd_hit2), 64'(h2));
      check("m_fwd_data2", fwd_data2, d2);
      if (rf_reg_write) n_wr++;
      // advance the model to the state after the coming rising edge
      if (n != 0) void'(exp_q.pop_front());
      if (mem_valid && e_mr && mem_rd != 5'd0) begin
        exp_q.push_back({mem_rd, mem_data}); n_acc++;
      end
      if (alu_valid && e_ar && alu_rd != 5'd0) begin
        exp_q.push_back({alu_rd, alu_data}); n_acc++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0; mem_rd = 5'd0; mem_data = 64'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 64'd0;
  endtask

  task automatic drive(input logic mv, input logic [4:0] mr, input logic [63:0] md,
                       input logic av, input logic [4:0] ar, input logic [63:0] ad);
    mem_valid = mv; mem_rd = mr; mem_data = md;
    alu_valid = av; alu_rd = ar; alu_data = ad;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset = 1'b1;
    idle();
    query_rs1 = 5'd0;
    query_rs2 = 5'd0;

    // reset: inputs presented during reset are ignored
    cyc();
    cyc(); drive(1'b1, 5'd4, 64'hAA, 1'b1, 5'd6, 64'hBB); #1;
    check("reset_mem_ready", 64'(mem_ready), 64'd0);
    check("reset_alu_ready", 64'(alu_ready), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    cyc(); reset = 1'b0; idle(); #1;
    check("post_reset_count", 64'(count), 64'd0);
    check("post_reset_rf_reg_write", 64'(rf_reg_write), 64'd0);

    // single ALU write
    cyc(); drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 64'h48); #1;
    check("single_alu_ready", 64'(alu_ready), 64'd1);
    cyc(); idle(); #1;
    check("single_rf_reg_write", 64'(rf_reg_write), 64'd1);
    check("single_rf_rd", 64'(rf_rd), 64'd5);
    check("single_rf_data", rf_write_data, 64'h48);
    check("single_count1", 64'(count), 64'd1);
    cyc(); #1;
    check("single_count0", 64'(count), 64'd0);

    // dual accept, same rd: load first, ALU second; forwarding sees the ALU value
    cyc(); drive(1'b1, 5'd3, 64'hDC2, 1'b1, 5'd3, 64'h111); #1;
    check("dual_mem_ready", 64'(mem_ready), 64'd1);
    check("dual_alu_ready", 64'(alu_ready), 64'd1);
    cyc(); idle(); query_rs1 = 5'd3; #1;
    check("dual_first_rd", 64'(rf_rd), 64'd3);
    check("dual_first_data", rf_write_data, 64'hDC2);
    check("dual_count2", 64'(count), 64'd2);
    check("dual_fwd_hit1", 64'(fwd_hit1), 64'd1);
    check("dual_fwd_data1", fwd_data1, 64'h111);
    cyc(); #1;
    check("dual_second_data", rf_write_data, 64'h111);
    check("dual_head_pending_fwd", fwd_data1, 64'h111);
    cyc(); #1;
    check("dual_empty_hit1", 64'(fwd_hit1), 64'd0);

    // x0 drop
    cyc(); drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'hFFFF); query_rs1 = 5'd0; #1;
    check("x0_alu_ready", 64'(alu_ready), 64'd1);
    cyc(); idle(); #1;
    check("x0_count", 64'(count), 64'd0);
    check("x0_rf_reg_write", 64'(rf_reg_write), 64'd0);
    check("x0_fwd_hit1", 64'(fwd_hit1), 64'd0);

    // forwarding priority / miss: build [rd7=1, rd9=2, rd7=3]
    cyc(); drive(1'b1, 5'd20, 64'hA0, 1'b1, 5'd21, 64'hA1);
    cyc(); drive(1'b1, 5'd7, 64'h1, 1'b1, 5'd9, 64'h2); #1;
    check("fwd_build_count2", 64'(count), 64'd2);
    cyc(); drive(1'b1, 5'd7, 64'h3, 1'b0, 5'd0, 64'd0); #1;
    check("fwd_build_count3", 64'(count), 64'd3);
    cyc(); idle(); query_rs2 = 5'd7; query_rs1 = 5'd9; #1;
    check("fwd_youngest_hit2", 64'(fwd_hit2), 64'd1);
    check("fwd_youngest_data2", fwd_data2, 64'h3);
    check("fwd_rs1_data", fwd_data1, 64'h2);
    check("fwd_head_rd", 64'(rf_rd), 64'd7);
    cyc(); query_rs2 = 5'd8; #1;
    check("fwd_miss_hit2", 64'(fwd_hit2), 64'd0);
    check("fwd_miss_data2", fwd_data2, 64'd0);
    cyc(); query_rs1 = 5'd0; query_rs2 = 5'd0;
    cyc(); cyc();

    // backpressure: both paths every cycle from empty, pointers wrap
    for (int k = 0; k < 10; k++) begin
      cyc();
      drive(1'b1, 5'(10 + k), 64'h1000 + 64'(k), 1'b1, 5'(20 + k), 64'h2000 + 64'(k));
      if (k == 2) begin
        #1;
        check("bp_count3", 64'(count), 64'd3);
        check("bp_mem_ready_free1", 64'(mem_ready), 64'd1);
        check("bp_alu_ready_free1", 64'(alu_ready), 64'd0);
      end
    end
    cyc(); idle();
    repeat (4) cyc();
    #1;
    check("bp_drained", 64'(count), 64'd0);

    // reset mid-operation with 3 entries queued
    cyc(); drive(1'b1, 5'd11, 64'hB1, 1'b1, 5'd12, 64'hB2);
    cyc(); drive(1'b1, 5'd13, 64'hB3, 1'b1, 5'd14, 64'hB4); #1;
    check("midrst_count2", 64'(count), 64'd2);
    cyc(); reset = 1'b1; drive(1'b1, 5'd15, 64'hB5, 1'b1, 5'd16, 64'hB6); #1;
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_rf_reg_write", 64'(rf_reg_write), 64'd0);
    check("midrst_mem_ready", 64'(mem_ready), 64'd0);
    check("midrst_alu_ready", 64'(alu_ready), 64'd0);
    cyc(); reset = 1'b0; idle(); #1;
    check("midrst_after_count", 64'(count), 64'd0);
    check("midrst_after_write", 64'(rf_reg_write), 64'd0);
    cyc(); #1;
    check("midrst_after_write2", 64'(rf_reg_write), 64'd0);

    // mixed traffic checked by the model
    for (int k = 0; k < 150; k++) begin
      cyc();
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 64'($urandom()),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 64'($urandom()));
      query_rs1 = 5'($urandom_range(0, 7));
      query_rs2 = 5'($urandom_range(0, 7));
    end
    cyc(); idle();
    repeat (5) cyc();
    #1;
    check("final_count", 64'(count), 64'd0);
    check("final_writes_equal_accepts", 64'(n_wr), 64'(n_acc - n_drop));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
